alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Sequencer and two-way arbiter for the shared combinational ALU in the multi-cycle RISC-V core. Two requesters (port 0: fetch/PC-update path, port 1: execute path) each present an operand pair and a 3-bit ALU operation with a valid/ready handshake. The block grants one request at a time, drives the ALU from registered operands, captures result and zero flag, and returns them to the granted requester with a valid/ready response handshake. The ALU itself stays outside the block; its inputs are driven from here and its outputs fed back.

## Interface
- `WIDTH`, 32, operand/result width; must equal the ALU's `WIDTH`.
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 2: bit i = requester i presents a request.
- `req_ready` out 2: bit i = request i accepted this cycle.
- `req_a0`, `req_b0` in WIDTH: requester 0 operands.
- `req_op0` in 3: requester 0 ALU operation.
- `req_a1`, `req_b1` in WIDTH: requester 1 operands.
- `req_op1` in 3: requester 1 ALU operation.
- `resp_valid` out 2: bit i = response for requester i is held.
- `resp_ready` in 2: bit i = requester i consumes its response.
- `resp_result` out WIDTH: captured ALU result, shared by both ports.
- `resp_z` out 1: captured zero flag.
- `alu_a`, `alu_b` out WIDTH: to ALU `a_in`/`b_in`.
- `alu_control` out 3: to ALU `ALUControl`.
- `alu_result` in WIDTH: from ALU `ALUResult`.
- `alu_z` in 1: from ALU `Z`.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state IDLE.
- IDLE: if no `req_valid` bit, stay. Otherwise select a winner (see Configuration), assert `req_ready[winner]` combinationally, and on that edge latch the winner's a/b/op and index into `op_a`, `op_b`, `op_ctl`, `owner`; go EXEC. The loser's `req_ready` stays 0; it must hold its request stable.
- EXEC: exactly one cycle. `alu_a`/`alu_b`/`alu_control` are driven from the registers during this cycle. At the closing edge, latch `alu_result` into `resp_result` and `alu_z` into `resp_z`; go RESP.
- RESP: `resp_valid[owner]` = 1, the other bit 0. Stay until `resp_ready[owner]` = 1, then go IDLE on that edge. `resp_ready` on the non-owner bit is ignored.
- `req_ready` is 0 in EXEC and RESP; no new request is accepted while an operation is in flight.
- `alu_a`/`alu_b`/`alu_control` are always driven from the operand registers, so they are also stable in IDLE and RESP.
- The op code passes through unmodified. Encodings: 000 add, 001 sub, 010 and, 110 or, 101 slt. Any other code gives the ALU default: result 0, Z = 1.
- Reset values: `req_ready` = 0, `resp_valid` = 0, `resp_result` = 0, `resp_z` = 0, `alu_a` = 0, `alu_b` = 0, `alu_control` = 000, `owner` = 0, round-robin pointer = 0 (port 0 preferred first).
- Reset asserted in EXEC or RESP aborts the operation. No response is ever issued for it.
- Both `req_valid` bits set in the same IDLE cycle: exactly one `req_ready` bit is set.

## Timing
- Accept edge N (handshake in IDLE) -> ALU evaluates in cycle N+1 -> `resp_valid` high from cycle N+2.
- With `resp_ready` held high, `resp_valid` is high for exactly one cycle and the block is back in IDLE at N+3.
- A new request can then be accepted in cycle N+3. Peak throughput is one operation per 3 cycles.
- `resp_result`/`resp_z` hold their values until the next EXEC capture, even after the response is consumed.
- No combinational path from `req_*` or `resp_ready` to `alu_*`.
- The only combinational input-to-output path is `req_valid` -> `req_ready`, in IDLE.

## Configuration
- `ALU_ARBITER_RR_EN` defined: round-robin arbitration. A 1-bit pointer names the preferred port. After each grant the pointer moves to the non-granted port. A lone valid requester always wins.
- `ALU_ARBITER_RR_EN` undefined: fixed priority, port 0 always wins a tie. The pointer register is not instantiated.

## Test plan
- Reset then idle: all outputs at reset values, `req_ready` = 00 for 5 cycles with no `req_valid`.
- Port 0 add: a=5, b=7, op=000 -> `req_ready` = 01, then `resp_valid` = 01 two cycles later with `resp_result` = 12, `resp_z` = 0. Consume with `resp_ready` = 01; back in IDLE.
- Port 1 sub, zero case: a=9, b=9, op=001 -> result 0, Z = 1. Hold `resp_ready` low for 4 cycles: `resp_valid` = 10 stays high, result stable.
- Tie, RR build: both ports valid continuously, port 0 {3,1,101}, port 1 {0xF0,0x0F,110}. Grants alternate 0,1,0,1; results 0 and 0xFF; `resp_valid` never shows both bits set.
- Same tie with the macro undefined: port 0 is granted every time, and port 1 only after port 0 drops `req_valid`.
- Reset asserted during EXEC of port 0 request {1,1,000}: no `resp_valid`, all outputs at reset values the next cycle, and a following request completes normally.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-port arbiter and 3-phase sequencer (IDLE -> EXEC -> RESP) for the shared ALU.
// Define ALU_ARBITER_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [2:0]       req_op0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [2:0]       req_op1,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_z,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_z
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] op_a, op_b;
  logic [2:0]       op_ctl;
  logic             owner;
  logic             winner;
  logic             grant;

  assign grant = (state == IDLE) && (req_valid != 2'b00);

`ifdef ALU_ARBITER_RR_EN
  logic rr_ptr;

  // Pointer names the preferred port; after a grant the other port gets preference.
  always_ff @(posedge clk) begin
    if (reset)
      rr_ptr <= 1'b0;
    else if (grant)
      rr_ptr <= ~winner;
  end

  always_comb begin
    winner = rr_ptr;
    if (req_valid == 2'b01)
      winner = 1'b0;
    else if (req_valid == 2'b10)
      winner = 1'b1;
  end
`else
  always_comb winner = ~req_valid[0];
`endif

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 2'b00;
    resp_valid = 2'b00;
    case (state)
      IDLE: begin
        if (grant) begin
          req_ready[winner] = 1'b1;
          state_next        = EXEC;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        resp_valid[owner] = 1'b1;
        if (resp_ready[owner])
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand registers feed the ALU directly, so no input reaches alu_* combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_a        <= '0;
      op_b        <= '0;
      op_ctl      <= 3'b000;
      owner       <= 1'b0;
      resp_result <= '0;
      resp_z      <= 1'b0;
    end else begin
      if (grant) begin
        op_a   <= winner ? req_a1  : req_a0;
        op_b   <= winner ? req_b1  : req_b0;
        op_ctl <= winner ? req_op1 : req_op0;
        owner  <= winner;
      end
      if (state == EXEC) begin
        resp_result <= alu_result;
        resp_z      <= alu_z;
      end
    end
  end

  assign alu_a       = op_a;
  assign alu_b       = op_b;
  assign alu_control = op_ctl;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural ALU and an arbitration reference model.
// Honours ALU_ARBITER_RR_EN the same way as the design.
module tb_alu_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req_valid, req_ready, resp_valid, resp_ready;
  logic [W-1:0] req_a0, req_b0, req_a1, req_b1;
  logic [2:0]   req_op0, req_op1;
  logic [W-1:0] resp_result, alu_a, alu_b, alu_result;
  logic         resp_z, alu_z;
  logic [2:0]   alu_control;

  int   n_checks = 0;
  int   n_errors = 0;
  logic ptr_model = 1'b0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0),
    .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_z(resp_z),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_z(alu_z)
  );

  function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] op);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b110:  return a | b;
      3'b101:  return {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: return '0;
    endcase
  endfunction

  // External ALU stand-in
  always_comb begin
    alu_result = ref_alu(alu_a, alu_b, alu_control);
    alu_z      = (alu_result == '0);
  end

  function automatic int pick_winner(input logic [1:0] v);
`ifdef ALU_ARBITER_RR_EN
    if (v == 2'b11) return ptr_model ? 1 : 0;
    return v[1] ? 1 : 0;
`else
    return v[0] ? 0 : 1;
`endif
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset      = 1'b1;
    req_valid  = 2'b00;
    resp_ready = 2'b00;
    step;
    step;
    reset     = 1'b0;
    ptr_model = 1'b0;
  endtask

  // One full accept/execute/respond sequence for the expected winner w, owner stalls for hold cycles.
  task automatic run_txn(input string tag, input int w, input int hold);
    logic [W-1:0] ea, eb, er;
    logic [2:0]   eop;
    logic [1:0]   onehot;
    logic         nb;
    ea     = (w == 1) ? req_a1  : req_a0;
    eb     = (w == 1) ? req_b1  : req_b0;
    eop    = (w == 1) ? req_op1 : req_op0;
    er     = ref_alu(ea, eb, eop);
    onehot = (w == 1) ? 2'b10 : 2'b01;
    #1;
    n_checks++;
    if (req_ready !== onehot) begin
      n_errors++;
      $display("[TB] FAIL %s grant: req_ready got %b expected %b", tag, req_ready, onehot);
    end
    step;
`ifdef ALU_ARBITER_RR_EN
    ptr_model = (w == 0);
`endif
    n_checks++;
    if ({req_ready, resp_valid, alu_a, alu_b, alu_control} !== {4'b0000, ea, eb, eop}) begin
      n_errors++;
      $display("[TB] FAIL %s exec: rdy/vld %b/%b alu %h %h %b expected 00/00 %h %h %b",
               tag, req_ready, resp_valid, alu_a, alu_b, alu_control, ea, eb, eop);
    end
    step;
    for (int i = 0; i <= hold; i++) begin
      nb = 1'($urandom_range(0, 1));
      n_checks++;
      if ({req_ready, resp_valid, resp_result, resp_z} !== {2'b00, onehot, er, (er == '0)}) begin
        n_errors++;
        $display("[TB] FAIL %s resp[%0d]: rdy %b vld %b result %h z %b expected 00 %b %h %b",
                 tag, i, req_ready, resp_valid, resp_result, resp_z, onehot, er, (er == '0));
      end
      resp_ready = (i == hold) ? (onehot | (nb ? ~onehot : 2'b00)) : (nb ? ~onehot : 2'b00);
      step;
    end
    resp_ready = 2'b00;
    n_checks++;
    if ({resp_valid, resp_result} !== {2'b00, er}) begin
      n_errors++;
      $display("[TB] FAIL %s done: vld %b result %h expected 00 %h", tag, resp_valid, resp_result, er);
    end
  endtask

  task automatic test_reset;
    do_reset;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if ({req_ready, resp_valid, resp_result, resp_z, alu_a, alu_b, alu_control} !== '0) begin
        n_errors++;
        $display("[TB] FAIL reset_idle[%0d]: rdy %b vld %b res %h z %b alu %h %h %b expected all 0",
                 i, req_ready, resp_valid, resp_result, resp_z, alu_a, alu_b, alu_control);
      end
      step;
    end
  endtask

  task automatic test_port0_add;
    req_a0 = 5; req_b0 = 7; req_op0 = 3'b000;
    req_valid = 2'b01;
    run_txn("port0_add", 0, 0);
    req_valid = 2'b00;
    n_checks++;
    if (resp_result !== 32'd12 || resp_z !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL port0_add value: result %0d z %b expected 12 0", resp_result, resp_z);
    end
  endtask

  task automatic test_port1_sub_stall;
    req_a1 = 9; req_b1 = 9; req_op1 = 3'b001;
    req_valid = 2'b10;
    run_txn("port1_sub", 1, 4);
    req_valid = 2'b00;
    n_checks++;
    if (resp_result !== 32'd0 || resp_z !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL port1_sub value: result %0d z %b expected 0 1", resp_result, resp_z);
    end
  endtask

  task automatic test_tie;
    do_reset;
    req_a0 = 3;     req_b0 = 1;     req_op0 = 3'b101;
    req_a1 = 'hF0;  req_b1 = 'h0F;  req_op1 = 3'b110;
    req_valid = 2'b11;
`ifdef ALU_ARBITER_RR_EN
    run_txn("tie_rr0", 0, 0);
    run_txn("tie_rr1", 1, 0);
    run_txn("tie_rr2", 0, 1);
    run_txn("tie_rr3", 1, 0);
`else
    run_txn("tie_fp0", 0, 0);
    run_txn("tie_fp1", 0, 1);
    run_txn("tie_fp2", 0, 0);
    req_valid = 2'b10;
    run_txn("tie_fp3", 1, 0);
`endif
    req_valid = 2'b00;
  endtask

  task automatic test_reset_in_exec;
    req_a0 = 1; req_b0 = 1; req_op0 = 3'b000;
    req_valid = 2'b01;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_errors++;
      $display("[TB] FAIL abort_grant: req_ready got %b expected 01", req_ready);
    end
    step;
    req_valid = 2'b00;
    reset     = 1'b1;
    step;
    reset     = 1'b0;
    ptr_model = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({req_ready, resp_valid, resp_result, resp_z, alu_a, alu_b, alu_control} !== '0) begin
        n_errors++;
        $display("[TB] FAIL abort_state[%0d]: rdy %b vld %b res %h z %b alu %h %h %b expected all 0",
                 i, req_ready, resp_valid, resp_result, resp_z, alu_a, alu_b, alu_control);
      end
      step;
    end
    req_valid = 2'b01;
    run_txn("after_abort", 0, 0);
    req_valid = 2'b00;
  endtask

  task automatic test_random;
    logic [1:0] v;
    do_reset;
    for (int k = 0; k < 24; k++) begin
      v       = 2'($urandom_range(1, 3));
      req_a0  = $urandom;  req_b0 = ($urandom_range(0, 3) == 0) ? req_a0 : $urandom;
      req_a1  = $urandom;  req_b1 = ($urandom_range(0, 3) == 0) ? req_a1 : $urandom;
      req_op0 = 3'($urandom_range(0, 7));
      req_op1 = 3'($urandom_range(0, 7));
      req_valid = v;
      run_txn("random", pick_winner(v), $urandom_range(0, 2));
      req_valid = 2'b00;
      if ($urandom_range(0, 1) == 1) step;
    end
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 2'b00; resp_ready = 2'b00;
    req_a0 = '0; req_b0 = '0; req_op0 = 3'b000;
    req_a1 = '0; req_b1 = '0; req_op1 = 3'b000;
    test_reset;
    test_port0_add;
    test_port1_sub_stall;
    test_tie;
    test_reset_in_exec;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
